// File: rtl/mbgd_pkg.sv
// Shared constants, FSM state type and stage-width helper for the MBGD dot-product reducer.
// Optional build macro MBGD_REDUCE_SIGNED_EN switches operands to two's-complement.
package mbgd_pkg;
    localparam int N         = 8;
    localparam int N_bit     = 3;
    localparam int DW        = 8;
    localparam int BEATS     = 4;
    localparam int BEATS_BIT = 2;
    localparam int ACC_W     = 2*DW + N_bit + BEATS_BIT;

`ifdef MBGD_REDUCE_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef enum logic {IDLE, ACCUM} state_e;

    // Width of adder-tree stage k (stage 0 is the raw product).
    function automatic int stage_w(input int k);
        return 2*DW + k;
    endfunction
endpackage

// File: rtl/mbgd_add_tree.sv
// Pipelined N-input adder tree: N_bit register stages, each one bit wider than the last,
// all stages and their valid bits advancing together on adv.
module mbgd_add_tree
    import mbgd_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        adv,
    input  logic                        in_vld,
    input  logic [2*DW*N-1:0]           products,
    output logic                        out_vld,
    output logic [stage_w(N_bit)-1:0]   out_sum
);
    logic [N_bit:0] vld_pipe;
    logic [N_bit:1] vld_pipe_q, vld_pipe_d;

    assign vld_pipe = {vld_pipe_q, in_vld};

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        if (adv) vld_pipe_d = vld_pipe[N_bit-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) vld_pipe_q <= '0;
        else       vld_pipe_q <= vld_pipe_d;
    end

    for (genvar k = 1; k <= N_bit; k++) begin : g_stg
        localparam int W = stage_w(k);
        localparam int M = N >> k;

        logic [M-1:0][W-1:0]   sum_q, sum_d;
        logic [2*M-1:0][W-2:0] src;

        if (k == 1) begin : g_src
            assign src = products;
        end else begin : g_src
            assign src = g_stg[k-1].sum_q;
        end

        // Extension bit is the operand MSB in the signed build, zero otherwise.
        always_comb begin
            sum_d = sum_q;
            if (adv) begin
                for (int j = 0; j < M; j++) begin
                    sum_d[j] = {SIGNED_EN & src[2*j][W-2],   src[2*j]}
                             + {SIGNED_EN & src[2*j+1][W-2], src[2*j+1]};
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) sum_q <= '0;
            else       sum_q <= sum_d;
        end
    end

    assign out_vld = vld_pipe[N_bit];
    assign out_sum = g_stg[N_bit].sum_q[0];
endmodule

// File: rtl/mbgd_dot_prod_reduce.sv
// MBGD dot-product reducer: adder tree per beat, BEATS-beat accumulator FSM, valid/ready result.
// Build with MBGD_REDUCE_SIGNED_EN defined for signed products (port list unchanged).
module mbgd_dot_prod_reduce
    import mbgd_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*DW*N-1:0]     products,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      dot_sum,
    output logic [BEATS_BIT-1:0]  beat_idx
);
    localparam int TW = stage_w(N_bit);

    logic                 adv;
    logic                 tree_vld;
    logic [TW-1:0]        tree_sum;
    logic [ACC_W-1:0]     tree_ext;

    state_e               state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [ACC_W-1:0]     dot_sum_q, dot_sum_d;
    logic                 out_valid_q, out_valid_d;
    logic [BEATS_BIT-1:0] beat_idx_q, beat_idx_d;

    // One enable stalls the whole pipe while a finished result waits for the consumer.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    mbgd_add_tree u_tree (
        .clk      (clk),
        .reset    (reset),
        .adv      (adv),
        .in_vld   (in_valid),
        .products (products),
        .out_vld  (tree_vld),
        .out_sum  (tree_sum)
    );

    assign tree_ext = {{(ACC_W-TW){SIGNED_EN & tree_sum[TW-1]}}, tree_sum};

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        dot_sum_d   = dot_sum_q;
        out_valid_d = out_valid_q;
        beat_idx_d  = beat_idx_q;
        if (adv) begin
            // Any held result is transferred on this edge; a new one may replace it below.
            out_valid_d = 1'b0;
            if (tree_vld) begin
                if (beat_idx_q == BEATS_BIT'(BEATS-1)) begin
                    dot_sum_d   = acc_q + tree_ext;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    beat_idx_d  = '0;
                    state_d     = IDLE;
                end else if (state_q == IDLE) begin
                    acc_d      = tree_ext;
                    beat_idx_d = BEATS_BIT'(1);
                    state_d    = ACCUM;
                end else begin
                    acc_d      = acc_q + tree_ext;
                    beat_idx_d = beat_idx_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            dot_sum_q   <= '0;
            out_valid_q <= 1'b0;
            beat_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            dot_sum_q   <= dot_sum_d;
            out_valid_q <= out_valid_d;
            beat_idx_q  <= beat_idx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dot_sum   = dot_sum_q;
    assign beat_idx  = beat_idx_q;
endmodule

// File: tb/tb_mbgd_dot_prod_reduce.sv
// Self-checking bench for mbgd_dot_prod_reduce: directed cases plus randomized traffic
// scored against a beat-level arithmetic model.
module tb_mbgd_dot_prod_reduce;
    import mbgd_pkg::*;

    logic                 clk;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [2*DW*N-1:0]    products;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_W-1:0]     dot_sum;
    logic [BEATS_BIT-1:0] beat_idx;

    int n_cmp = 0;
    int n_err = 0;

    int     exp_q[$];
    int     res_log[$];
    longint part_sum;
    int     part_cnt;

    mbgd_dot_prod_reduce dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .products  (products),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dot_sum   (dot_sum),
        .beat_idx  (beat_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint vec_sum(input logic [2*DW*N-1:0] p);
        longint s = 0;
        for (int i = 0; i < N; i++) begin
`ifdef MBGD_REDUCE_SIGNED_EN
            s += longint'($signed(p[2*DW*i +: 2*DW]));
`else
            s += longint'(p[2*DW*i +: 2*DW]);
`endif
        end
        return s;
    endfunction

    // Reference model: counts accepted beats and sums whole vectors.
    always @(negedge clk) begin
        if (reset) begin
            part_sum = 0;
            part_cnt = 0;
            exp_q.delete();
        end else begin
            chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (out_valid && out_ready) begin
                res_log.push_back(int'(dot_sum));
                if (exp_q.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
                else                   chk("dot_sum", 32'(dot_sum), exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                part_sum += vec_sum(products);
                part_cnt++;
                if (part_cnt == BEATS) begin
                    exp_q.push_back(int'(part_sum & ((64'd1 << ACC_W) - 1)));
                    part_sum = 0;
                    part_cnt = 0;
                end
            end
        end
    end

    task automatic set_all(input logic [2*DW-1:0] v);
        for (int i = 0; i < N; i++) products[2*DW*i +: 2*DW] = v;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_beat(input logic [2*DW-1:0] v);
        int waited = 0;
        set_all(v);
        in_valid = 1'b1;
        while (!in_ready && waited < 50) begin
            tick(1);
            waited++;
        end
        if (!in_ready) chk("beat_accept_timeout", 32'(in_ready), 32'd1);
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int waited = 0;
        while (!out_valid && waited < 50) begin
            tick(1);
            waited++;
        end
        chk(tag, 32'(out_valid), 32'd1);
    endtask

    initial begin : main
        int bi[8];
        int ov[8];
        int ds6;
        int exp_bi[8];
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        products  = '0;
        part_sum  = 0;
        part_cnt  = 0;
        tick(2);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dot_sum",   32'(dot_sum),   32'd0);
        chk("rst_beat_idx",  32'(beat_idx),  32'd0);
        reset = 1'b0;
        tick(1);
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        // 1: four beats of 1, latency and beat_idx progression
        exp_bi = '{0, 0, 0, 1, 2, 3, 0, 0};
        set_all(16'd1);
        in_valid = 1'b1;
        ds6 = 0;
        for (int c = 0; c < 8; c++) begin
            tick(1);
            if (c == 3) in_valid = 1'b0;
            bi[c] = int'(beat_idx);
            ov[c] = int'(out_valid);
            if (c == 6) ds6 = int'(dot_sum);
        end
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("t1_beat_idx%0d", c), 32'(bi[c]), 32'(exp_bi[c]));
            chk($sformatf("t1_out_valid%0d", c), 32'(ov[c]), (c == 6) ? 32'd1 : 32'd0);
        end
        chk("t1_dot_sum", 32'(ds6), 32'd32);

        // 2: maximum unsigned products, no overflow
        for (int b = 0; b < 4; b++) drive_beat(16'hFE01);
        wait_out("t2_wait");
        chk("t2_dot_sum", 32'(dot_sum), 32'h1FC020);
        tick(4);

        // 3: backpressure holds result, tree and input side
        out_ready = 1'b0;
        for (int b = 0; b < 4; b++) drive_beat(16'd3);
        drive_beat(16'd5);
        wait_out("t3_wait");
        for (int c = 0; c < 5; c++) begin
            chk("t3_in_ready",  32'(in_ready),  32'd0);
            chk("t3_out_valid", 32'(out_valid), 32'd1);
            chk("t3_dot_sum",   32'(dot_sum),   32'd96);
            tick(1);
        end
        out_ready = 1'b1;
        tick(1);
        chk("t3_post_valid", 32'(out_valid), 32'd0);
        chk("t3_post_ready", 32'(in_ready),  32'd1);
        for (int b = 0; b < 3; b++) drive_beat(16'd5);
        wait_out("t3b_wait");
        chk("t3b_dot_sum", 32'(dot_sum), 32'd160);
        tick(4);

        // 4: reset mid dot-product discards the partial sum
        res_log.delete();
        drive_beat(16'd2);
        drive_beat(16'd2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t4_beat_idx", 32'(beat_idx),  32'd0);
        chk("t4_valid",    32'(out_valid), 32'd0);
        for (int b = 0; b < 4; b++) drive_beat(16'd1);
        tick(8);
        chk("t4_nres", 32'(res_log.size()), 32'd1);
        if (res_log.size() > 0) chk("t4_sum", 32'(res_log[0]), 32'd32);

        // 5: gapped back-to-back results
        res_log.delete();
        for (int b = 1; b <= 8; b++) begin
            drive_beat(16'(b));
            if (b % 2 == 1) tick(1);
        end
        tick(8);
        chk("t5_nres", 32'(res_log.size()), 32'd2);
        if (res_log.size() == 2) begin
            chk("t5_sum0", 32'(res_log[0]), 32'd80);
            chk("t5_sum1", 32'(res_log[1]), 32'd208);
        end

`ifdef MBGD_REDUCE_SIGNED_EN
        // 6: signed -1 products
        for (int b = 0; b < 4; b++) drive_beat(16'hFFFF);
        wait_out("t6_wait");
        chk("t6_dot_sum", 32'(dot_sum), 32'h1FFFE0);
        tick(4);
`endif

        // Randomized traffic with stalls and one mid-stream reset
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            for (int i = 0; i < N; i++) products[2*DW*i +: 2*DW] = 16'($urandom);
            reset     = (c == 300);
            tick(1);
        end
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick(12);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_partial_beats", 32'(beat_idx), 32'(part_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
